// File: rtl/alu_pkg.sv
// Shared definitions for the ALU shift datapath: mode codes, FSM encoding
// and a ceil(log2) helper for sizing count fields.
package alu_pkg;

  localparam logic [2:0] MODE_LSL = 3'b000;
  localparam logic [2:0] MODE_LSR = 3'b001;
  localparam logic [2:0] MODE_ASR = 3'b010;
  localparam logic [2:0] MODE_ROR = 3'b011;
  localparam logic [2:0] MODE_ROL = 3'b100;

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StDone
  } state_e;

  function automatic int unsigned clogb2(input int unsigned value);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < value) begin
      r = r + 1;
    end
    if (r == 0) begin
      r = 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/multi_step_shifter_shift_step.sv
// Combinational single-step shifter: moves data by amt positions in the given
// mode and reports the last bit moved out (or the wrapped bit for rotates).
module shift_step
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CNT_W = 4
) (
  input  logic [WIDTH-1:0] data,
  input  logic [2:0]       mode,
  input  logic [CNT_W-1:0] amt,
  output logic [WIDTH-1:0] result,
  output logic             out_bit
);

  // One guard bit beyond the data catches the final bit shifted out.
  logic [WIDTH:0]   lsl_w;
  logic [WIDTH:0]   lsr_w;
  logic [WIDTH:0]   asr_w;
  logic [WIDTH-1:0] ror_w;
  logic [WIDTH-1:0] rol_w;

  always_comb begin
    lsl_w = {1'b0, data} << amt;
    lsr_w = {data, 1'b0} >> amt;
    asr_w = $signed({data, 1'b0}) >>> amt;
    ror_w = (data >> amt) | (data << (WIDTH - 32'(amt)));
    rol_w = (data << amt) | (data >> (WIDTH - 32'(amt)));

    result  = data;
    out_bit = 1'b0;
    case (mode)
      MODE_LSL: begin
        result  = lsl_w[WIDTH-1:0];
        out_bit = lsl_w[WIDTH];
      end
      MODE_LSR: begin
        result  = lsr_w[WIDTH:1];
        out_bit = lsr_w[0];
      end
      MODE_ASR: begin
        result  = asr_w[WIDTH:1];
        out_bit = asr_w[0];
      end
      MODE_ROR: begin
        result  = ror_w;
        out_bit = ror_w[WIDTH-1];
      end
      MODE_ROL: begin
        result  = rol_w;
        out_bit = rol_w[0];
      end
      default: begin
        result  = data;
        out_bit = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/multi_step_shifter.sv
// Sequential shift/rotate unit: moves up to STEP positions per clock under a
// start/ready/done handshake, holding result and flags until the next start.
module multi_step_shifter
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned STEP  = 1,
  parameter int unsigned CNT_W = clogb2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       mode,
  input  logic [CNT_W-1:0] shift_count,
  input  logic [WIDTH-1:0] data_in,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] data_out,
  output logic             carry,
  output logic             zero,
  output logic             negative,
  output logic             overflow,
  output logic             mode_err
);

  localparam logic [CNT_W-1:0] StepC = CNT_W'(STEP);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [2:0]       mode_q, mode_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic             msb_q, msb_d;
  logic             carry_q, carry_d;
  logic             zero_q, zero_d;
  logic             neg_q, neg_d;
  logic             ovf_q, ovf_d;
  logic             err_q, err_d;

  logic [CNT_W-1:0] amt;
  logic [WIDTH-1:0] step_result;
  logic             step_out;
  logic             mode_legal;

  assign amt        = (rem_q < StepC) ? rem_q : StepC;
  assign mode_legal = (mode <= MODE_ROL);

  shift_step #(
    .WIDTH(WIDTH),
    .CNT_W(CNT_W)
  ) u_step (
    .data   (data_q),
    .mode   (mode_q),
    .amt    (amt),
    .result (step_result),
    .out_bit(step_out)
  );

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    mode_d  = mode_q;
    rem_d   = rem_q;
    msb_d   = msb_q;
    carry_d = carry_q;
    zero_d  = zero_q;
    neg_d   = neg_q;
    ovf_d   = ovf_q;
    err_d   = err_q;

    case (state_q)
      StIdle, StDone: begin
        if (start) begin
          data_d  = data_in;
          mode_d  = mode;
          rem_d   = shift_count;
          msb_d   = data_in[WIDTH-1];
          carry_d = 1'b0;
          ovf_d   = 1'b0;
          err_d   = !mode_legal;
          if (mode_legal && (shift_count != '0)) begin
            zero_d  = 1'b0;
            neg_d   = 1'b0;
            state_d = StShift;
          end else begin
            // Passthrough: this accept edge is also the DONE entry edge.
            zero_d  = (data_in == '0);
            neg_d   = data_in[WIDTH-1];
            state_d = StDone;
          end
        end
      end
      StShift: begin
        data_d  = step_result;
        carry_d = step_out;
        rem_d   = rem_q - amt;
        if (rem_d == '0) begin
          zero_d  = (step_result == '0);
          neg_d   = step_result[WIDTH-1];
          ovf_d   = (mode_q == MODE_LSL) && (step_result[WIDTH-1] != msb_q);
          state_d = StDone;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      data_q  <= '0;
      mode_q  <= '0;
      rem_q   <= '0;
      msb_q   <= 1'b0;
      carry_q <= 1'b0;
      zero_q  <= 1'b0;
      neg_q   <= 1'b0;
      ovf_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      mode_q  <= mode_d;
      rem_q   <= rem_d;
      msb_q   <= msb_d;
      carry_q <= carry_d;
      zero_q  <= zero_d;
      neg_q   <= neg_d;
      ovf_q   <= ovf_d;
      err_q   <= err_d;
    end
  end

  assign ready    = (state_q != StShift);
  assign done     = (state_q == StDone);
  assign data_out = data_q;
  assign carry    = carry_q;
  assign zero     = zero_q;
  assign negative = neg_q;
  assign overflow = ovf_q;
  assign mode_err = err_q;

endmodule

// File: tb/tb_multi_step_shifter.sv
// Randomised bench for multi_step_shifter: three instances (STEP 1, 3, 4) share
// stimulus and are checked against a whole-operation arithmetic model.
module tb_multi_step_shifter;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  mode;
  logic [3:0]  shift_count;
  logic [15:0] data_in;

  logic [2:0]  rdy, dn, cy, zr, ng, ov, er;
  logic [15:0] dout [3];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  multi_step_shifter #(.WIDTH(16), .STEP(1)) u_s1 (
    .clk(clk), .reset(reset), .start(start), .mode(mode), .shift_count(shift_count),
    .data_in(data_in), .ready(rdy[0]), .done(dn[0]), .data_out(dout[0]), .carry(cy[0]),
    .zero(zr[0]), .negative(ng[0]), .overflow(ov[0]), .mode_err(er[0])
  );
  multi_step_shifter #(.WIDTH(16), .STEP(3)) u_s3 (
    .clk(clk), .reset(reset), .start(start), .mode(mode), .shift_count(shift_count),
    .data_in(data_in), .ready(rdy[1]), .done(dn[1]), .data_out(dout[1]), .carry(cy[1]),
    .zero(zr[1]), .negative(ng[1]), .overflow(ov[1]), .mode_err(er[1])
  );
  multi_step_shifter #(.WIDTH(16), .STEP(4)) u_s4 (
    .clk(clk), .reset(reset), .start(start), .mode(mode), .shift_count(shift_count),
    .data_in(data_in), .ready(rdy[2]), .done(dn[2]), .data_out(dout[2]), .carry(cy[2]),
    .zero(zr[2]), .negative(ng[2]), .overflow(ov[2]), .mode_err(er[2])
  );

  function automatic int step_of(input int i);
    return (i == 0) ? 1 : ((i == 1) ? 3 : 4);
  endfunction

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Whole-operation result: the total shift is independent of per-cycle chunking.
  task automatic model(input logic [2:0] m, input int n, input logic [15:0] d,
                       output logic [15:0] r, output logic c, output logic z,
                       output logic neg, output logic o, output logic e);
    r = d;
    c = 1'b0;
    o = 1'b0;
    e = (m > 3'd4);
    if (!e && n > 0) begin
      case (m)
        3'd0: begin r = d << n; c = d[16-n]; end
        3'd1: begin r = d >> n; c = d[n-1]; end
        3'd2: begin r = $signed(d) >>> n; c = d[n-1]; end
        3'd3: begin r = (d >> n) | (d << (16 - n)); c = r[15]; end
        default: begin r = (d << n) | (d >> (16 - n)); c = r[0]; end
      endcase
      if (m == 3'd0) o = (r[15] != d[15]);
    end
    z   = (r == 16'h0000);
    neg = r[15];
  endtask

  // Issues one operation, watches a fixed window of edges for done, then checks.
  // With poke set, a conflicting start is offered while every instance is shifting.
  task automatic run_op(input logic [2:0] m, input int n, input logic [15:0] d, input bit poke);
    int lat [3];
    logic [15:0] r;
    logic c, z, neg, o, e;
    int exp_lat;
    string s;
    @(negedge clk);
    start       = 1'b1;
    mode        = m;
    shift_count = n[3:0];
    data_in     = d;
    for (int i = 0; i < 3; i++) lat[i] = 0;
    for (int edge_n = 1; edge_n <= 24; edge_n++) begin
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      if (poke && edge_n == 2) begin
        start       = 1'b1;
        data_in     = ~d;
        mode        = 3'd1;
        shift_count = 4'd1;
      end
      for (int i = 0; i < 3; i++) if (lat[i] == 0 && dn[i]) lat[i] = edge_n;
    end
    model(m, n, d, r, c, z, neg, o, e);
    for (int i = 0; i < 3; i++) begin
      exp_lat = (e || n == 0) ? 1 : 1 + (n + step_of(i) - 1) / step_of(i);
      s = $sformatf("s%0d m%0d n%0d d%h", step_of(i), m, n, d);
      check_val({s, " data"}, 32'(dout[i]), 32'(r));
      check_val({s, " carry"}, 32'(cy[i]), 32'(c));
      check_val({s, " zero"}, 32'(zr[i]), 32'(z));
      check_val({s, " neg"}, 32'(ng[i]), 32'(neg));
      check_val({s, " ovf"}, 32'(ov[i]), 32'(o));
      check_val({s, " err"}, 32'(er[i]), 32'(e));
      check_val({s, " latency"}, 32'(lat[i]), 32'(exp_lat));
      check_val({s, " ready"}, 32'(rdy[i]), 32'd1);
    end
  endtask

  task automatic check_reset_state(input string tag);
    for (int i = 0; i < 3; i++) begin
      check_val($sformatf("%s s%0d data", tag, step_of(i)), 32'(dout[i]), 32'd0);
      check_val($sformatf("%s s%0d flags", tag, step_of(i)),
                {26'd0, dn[i], cy[i], zr[i], ng[i], ov[i], er[i]}, 32'd0);
      check_val($sformatf("%s s%0d ready", tag, step_of(i)), 32'(rdy[i]), 32'd1);
    end
  endtask

  initial begin
    reset       = 1'b1;
    start       = 1'b0;
    mode        = 3'd0;
    shift_count = 4'd0;
    data_in     = 16'h0000;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_state("reset");
    reset = 1'b0;

    run_op(3'd0, 5, 16'h0001, 1'b0);
    check_val("lsl example s1 data", 32'(dout[0]), 32'h0020);
    run_op(3'd2, 4, 16'h8010, 1'b0);
    check_val("asr example s4 data", 32'(dout[2]), 32'hF801);
    run_op(3'd3, 4, 16'h00F1, 1'b0);
    run_op(3'd4, 1, 16'h8001, 1'b0);
    check_val("rol example s4 carry", 32'(cy[2]), 32'd1);
    run_op(3'd1, 7, 16'h0003, 1'b0);
    run_op(3'd1, 2, 16'h0003, 1'b0);
    run_op(3'd0, 0, 16'hA5A5, 1'b0);
    run_op(3'd7, 9, 16'h1234, 1'b0);
    run_op(3'd0, 15, 16'h7FFF, 1'b1);
    run_op(3'd2, 15, 16'h8000, 1'b0);

    // Reset mid-operation must discard everything.
    @(negedge clk);
    start = 1'b1; mode = 3'd0; shift_count = 4'd15; data_in = 16'hBEEF;
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
    end
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_reset_state("midreset");
    reset = 1'b0;

    for (int k = 0; k < 70; k++) begin
      logic [2:0] m;
      m = (($urandom % 8) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
      run_op(m, int'($urandom_range(0, 15)), 16'($urandom), 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
